uzorak_punjac: RTL and testbench
================================

Name: uzorak_punjac

Overview:
- Producer side of the Neural_net sample interface: receives 60 sonar features serially as 16-bit beats on a valid/ready stream and packs them into the 960-bit uzorak vector.
- Holds uzorak stable while the combinational net settles, captures indikator_1/indikator_2, and presents the result on a valid/ready result port.
- Sits between the sample source (memory reader / host link) and Neural_net.

Parameters:
- N_FEAT, 60, number of features per sample
- FEAT_W, 16, bits per feature
- SETTLE, 4, cycles uzorak is held before indicators are sampled (legal range 1..255)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- s_data  in  FEAT_W  feature beat
- s_valid  in  1  beat valid
- s_last  in  1  marks final feature of a sample
- s_ready  out  1  block accepts a beat
- uzorak  out  N_FEAT*FEAT_W  packed sample to Neural_net
- uzorak_valid  out  1  uzorak complete and stable
- indikator_1  in  1  net output 1
- indikator_2  in  1  net output 2
- rez_1  out  1  captured indikator_1
- rez_2  out  1  captured indikator_2
- rez_valid  out  1  result available
- rez_ready  in  1  result consumer accepts
- greska  out  1  one-cycle framing error pulse

Behaviour:
- Reset (async assert, sync release): state PUNJENJE, idx=0, uzorak=0, uzorak_valid=0, rez_1=rez_2=0, rez_valid=0, greska=0, s_ready=1.
- Packing: feature k (k-th accepted beat, k=0..N_FEAT-1) goes to uzorak[N_FEAT*FEAT_W-1-k*FEAT_W -: FEAT_W]. Feature 0 is at the MSB end.
- Beat accept: s_valid && s_ready on a rising edge.
- State PUNJENJE: s_ready=1, uzorak_valid=0.
  - Each accepted beat writes its slot and increments idx.
  - On the beat with idx==N_FEAT-1: idx returns to 0, next state SMIRIVANJE, settle counter loads SETTLE.
- State SMIRIVANJE: s_ready=0, uzorak_valid=1, uzorak frozen.
  - The counter decrements each cycle.
  - On the cycle the counter reaches 1: rez_1<=indikator_1, rez_2<=indikator_2, rez_valid<=1, next state REZULTAT.
- State REZULTAT: s_ready=0, uzorak_valid=1, rez_* held stable.
  - On rez_valid && rez_ready: rez_valid<=0, uzorak_valid<=0, next state PUNJENJE. s_ready=1 from the following cycle; uzorak keeps old contents until overwritten.
- Latency: last beat accepted at edge t → uzorak_valid high after t → rez_valid high after edge t+SETTLE.
- Throughput: with rez_ready held at 1, one sample per N_FEAT+SETTLE+1 cycles. No beat is accepted while a result is pending.
- uzorak contents are partial and undefined for the net while uzorak_valid=0. The consumer must qualify uzorak with uzorak_valid.
- s_data and s_last are ignored when s_valid=0.
- Reset mid-load or mid-settle: sample discarded, all registers return to reset values, no result emitted.
- rez_ready high while rez_valid=0 has no effect.

Optional Feature:
- Macro: UZORAK_FRAME_CHECK_EN
- Defined: s_last is checked on every accepted beat.
  - s_last=1 with idx<N_FEAT-1 (early end): greska pulses 1 cycle, idx<=0, frame discarded, state stays PUNJENJE.
  - s_last=0 with idx==N_FEAT-1 (missing end): greska pulses 1 cycle, idx<=0, frame discarded, no transition to SMIRIVANJE.
  - The next accepted beat is treated as feature 0.
- Not defined: s_last ignored. A frame completes purely on count. greska is tied to 0.

Test Plan:
- Reset, then 60 beats s_data=16'h0000+k (k=0..59), s_last on beat 59, rez_ready=1, indikator_1=1, indikator_2=0 → uzorak[959:944]=16'h0000, uzorak[15:0]=16'h003B; uzorak_valid rises the cycle after beat 59; rez_valid rises 4 edges after beat 59 with rez_1=1, rez_2=0; s_ready returns the cycle after the handshake.
- Same sample with rez_ready=0 for 20 cycles → rez_valid and uzorak held, s_ready=0 throughout, s_valid beats not accepted; release rez_ready → one handshake, then back to loading.
- s_valid toggled 50% randomly during a load → exactly 60 accepted beats packed in order; no gaps or duplicates in uzorak.
- rst_n pulsed low after beat 30, then a full sample of 16'hA5A5 → no rez_valid from the aborted frame; uzorak all 16'hA5A5; single result produced.
- With UZORAK_FRAME_CHECK_EN: s_last on beat 10 → greska one-cycle pulse, next 60 beats form a valid sample. Beat 59 without s_last → greska pulse, no rez_valid. Without the macro, the same stimuli → greska=0, sample completes on count.
- Change indikator_1 during SMIRIVANJE before the final settle cycle → rez_1 reflects the value present on the capture edge only.

Source files
------------

// File: rtl/uzorak_punjac_if.sv
// rtl/uzorak_punjac_if.sv - feature stream, packed sample and result handshake bundle for uzorak_punjac
interface uzorak_punjac_if #(
    parameter int N_FEAT = 60,
    parameter int FEAT_W = 16
);
    logic [FEAT_W-1:0]        s_data;
    logic                     s_valid;
    logic                     s_last;
    logic                     s_ready;
    logic [N_FEAT*FEAT_W-1:0] uzorak;
    logic                     uzorak_valid;
    logic                     indikator_1;
    logic                     indikator_2;
    logic                     rez_1;
    logic                     rez_2;
    logic                     rez_valid;
    logic                     rez_ready;
    logic                     greska;

    modport slave (
        input  s_data, s_valid, s_last, indikator_1, indikator_2, rez_ready,
        output s_ready, uzorak, uzorak_valid, rez_1, rez_2, rez_valid, greska
    );

    modport master (
        output s_data, s_valid, s_last, indikator_1, indikator_2, rez_ready,
        input  s_ready, uzorak, uzorak_valid, rez_1, rez_2, rez_valid, greska
    );
endinterface

// File: rtl/uzorak_punjac.sv
// rtl/uzorak_punjac.sv - packs 60x16-bit feature beats into uzorak, settles, captures net indicators
// Optional s_last framing check enabled by defining UZORAK_FRAME_CHECK_EN.
module uzorak_punjac #(
    parameter int N_FEAT = 60,
    parameter int FEAT_W = 16,
    parameter int SETTLE = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    uzorak_punjac_if.slave    bus
);
    localparam int VEC_W = N_FEAT * FEAT_W;
    localparam int IDX_W = $clog2(N_FEAT);
    localparam int LSB_W = $clog2(VEC_W);

    typedef enum logic [1:0] {PUNJENJE, SMIRIVANJE, REZULTAT} state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_idx;
    logic [7:0]         r_cnt;
    logic [VEC_W-1:0]   r_uzorak;
    logic               r_uzorak_valid;
    logic               r_s_ready;
    logic               r_rez_1;
    logic               r_rez_2;
    logic               r_rez_valid;

    logic               w_accept;
    logic               w_last_slot;
    logic [LSB_W-1:0]   w_lsb;

    assign w_accept    = bus.s_valid && r_s_ready;
    assign w_last_slot = (r_idx == IDX_W'(N_FEAT - 1));
    // Feature 0 lands at the MSB end of the vector.
    assign w_lsb       = LSB_W'((N_FEAT - 1 - int'(r_idx)) * FEAT_W);

`ifdef UZORAK_FRAME_CHECK_EN
    logic r_greska;
    logic w_frame_err;
    assign w_frame_err = (bus.s_last != w_last_slot);
    assign bus.greska  = r_greska;
`else
    assign bus.greska  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= PUNJENJE;
            r_idx          <= '0;
            r_cnt          <= '0;
            r_uzorak       <= '0;
            r_uzorak_valid <= 1'b0;
            r_s_ready      <= 1'b1;
            r_rez_1        <= 1'b0;
            r_rez_2        <= 1'b0;
            r_rez_valid    <= 1'b0;
`ifdef UZORAK_FRAME_CHECK_EN
            r_greska       <= 1'b0;
`endif
        end else begin
`ifdef UZORAK_FRAME_CHECK_EN
            r_greska <= 1'b0;
`endif
            case (r_state)
                PUNJENJE: begin
                    if (w_accept) begin
`ifdef UZORAK_FRAME_CHECK_EN
                        if (w_frame_err) begin
                            r_greska <= 1'b1;
                            r_idx    <= '0;
                        end else
`endif
                        begin
                            r_uzorak[w_lsb +: FEAT_W] <= bus.s_data;
                            if (w_last_slot) begin
                                r_idx          <= '0;
                                r_cnt          <= 8'(SETTLE);
                                r_s_ready      <= 1'b0;
                                r_uzorak_valid <= 1'b1;
                                r_state        <= SMIRIVANJE;
                            end else begin
                                r_idx <= r_idx + 1'b1;
                            end
                        end
                    end
                end
                SMIRIVANJE: begin
                    if (r_cnt == 8'd1) begin
                        r_rez_1     <= bus.indikator_1;
                        r_rez_2     <= bus.indikator_2;
                        r_rez_valid <= 1'b1;
                        r_state     <= REZULTAT;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                REZULTAT: begin
                    if (r_rez_valid && bus.rez_ready) begin
                        r_rez_valid    <= 1'b0;
                        r_uzorak_valid <= 1'b0;
                        r_s_ready      <= 1'b1;
                        r_state        <= PUNJENJE;
                    end
                end
                default: r_state <= PUNJENJE;
            endcase
        end
    end

    assign bus.s_ready      = r_s_ready;
    assign bus.uzorak       = r_uzorak;
    assign bus.uzorak_valid = r_uzorak_valid;
    assign bus.rez_1        = r_rez_1;
    assign bus.rez_2        = r_rez_2;
    assign bus.rez_valid    = r_rez_valid;
endmodule

// File: tb/tb_uzorak_punjac.sv
// tb/tb_uzorak_punjac.sv - directed self-checking bench for uzorak_punjac
module tb_uzorak_punjac;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    uzorak_punjac_if #(.N_FEAT(60), .FEAT_W(16)) bus ();

    uzorak_punjac #(.N_FEAT(60), .FEAT_W(16), .SETTLE(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

`ifdef UZORAK_FRAME_CHECK_EN
    localparam logic FC = 1'b1;
`else
    localparam logic FC = 1'b0;
`endif

    task automatic chk(input string tag, input logic [959:0] obs, input logic [959:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [959:0] build(input logic [15:0] base, input logic [15:0] step);
        logic [959:0] v = '0;
        for (int k = 0; k < 60; k++)
            v[(59 - k) * 16 +: 16] = base + step * 16'(k);
        return v;
    endfunction

    // Drives beats k0..n-1 back to back; returns at the negedge after the last beat's edge.
    task automatic send_frame(input logic [15:0] base, input logic [15:0] step,
                              input int k0, input int n, input int last_at);
        for (int k = k0; k < n; k++) begin
            @(negedge clk);
            bus.s_valid = 1'b1;
            bus.s_data  = base + step * 16'(k);
            bus.s_last  = (k == last_at);
        end
        @(negedge clk);
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic wait_result(input string tag);
        int n = 0;
        while (!bus.rez_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 960'(bus.rez_valid), 960'(1));
    endtask

    initial begin
        logic seen;
        int   k;
        int   cyc;

        bus.s_data = '0; bus.s_valid = 1'b0; bus.s_last = 1'b0;
        bus.indikator_1 = 1'b0; bus.indikator_2 = 1'b0; bus.rez_ready = 1'b1;
        repeat (3) @(negedge clk);

        chk("rst_s_ready", 960'(bus.s_ready), 960'(1));
        chk("rst_uzorak", bus.uzorak, '0);
        chk("rst_uzorak_valid", 960'(bus.uzorak_valid), 960'(0));
        chk("rst_rez", 960'({bus.rez_valid, bus.rez_1, bus.rez_2}), 960'(0));
        chk("rst_greska", 960'(bus.greska), 960'(0));
        rst_n = 1'b1;

        // Basic sample with exact latency.
        bus.indikator_1 = 1'b1; bus.indikator_2 = 1'b0;
        send_frame(16'h0000, 16'd1, 0, 60, 59);
        chk("t1_uzorak_valid", 960'(bus.uzorak_valid), 960'(1));
        chk("t1_s_ready_low", 960'(bus.s_ready), 960'(0));
        chk("t1_msb_slot", 960'(bus.uzorak[959:944]), 960'(16'h0000));
        chk("t1_lsb_slot", 960'(bus.uzorak[15:0]), 960'(16'h003B));
        chk("t1_uzorak", bus.uzorak, build(16'h0000, 16'd1));
        for (int i = 1; i <= 3; i++) begin
            chk("t1_rez_valid_early", 960'(bus.rez_valid), 960'(0));
            @(negedge clk);
        end
        chk("t1_rez_valid_early", 960'(bus.rez_valid), 960'(0));
        @(negedge clk);
        chk("t1_rez_valid", 960'(bus.rez_valid), 960'(1));
        chk("t1_rez", 960'({bus.rez_1, bus.rez_2}), 960'(2'b10));
        @(negedge clk);
        chk("t1_after_hs_valid", 960'(bus.rez_valid), 960'(0));
        chk("t1_after_hs_ready", 960'(bus.s_ready), 960'(1));
        chk("t1_after_hs_uvalid", 960'(bus.uzorak_valid), 960'(0));

        // Back-pressure on the result port.
        bus.rez_ready = 1'b0;
        bus.indikator_1 = 1'b0; bus.indikator_2 = 1'b1;
        send_frame(16'h1000, 16'd1, 0, 60, 59);
        bus.s_valid = 1'b1; bus.s_data = 16'hDEAD;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            chk("t2_rez_held", 960'(bus.rez_valid), 960'(1));
            chk("t2_s_ready_low", 960'(bus.s_ready), 960'(0));
            @(negedge clk);
        end
        chk("t2_uzorak_held", bus.uzorak, build(16'h1000, 16'd1));
        chk("t2_rez", 960'({bus.rez_1, bus.rez_2}), 960'(2'b01));
        bus.s_valid = 1'b0; bus.rez_ready = 1'b1;
        @(negedge clk);
        chk("t2_release_valid", 960'(bus.rez_valid), 960'(0));
        chk("t2_release_ready", 960'(bus.s_ready), 960'(1));

        // Randomly gapped valid; idle cycles carry junk with s_last high.
        k = 0; cyc = 0;
        while (k < 60 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if ($urandom_range(0, 1) == 1) begin
                bus.s_valid = 1'b1; bus.s_data = 16'h2000 + 16'(k); bus.s_last = (k == 59);
                k++;
            end else begin
                bus.s_valid = 1'b0; bus.s_data = 16'hBAD0; bus.s_last = 1'b1;
            end
        end
        @(negedge clk);
        bus.s_valid = 1'b0; bus.s_last = 1'b0;
        chk("t3_uzorak_valid", 960'(bus.uzorak_valid), 960'(1));
        chk("t3_uzorak", bus.uzorak, build(16'h2000, 16'd1));
        wait_result("t3_result");
        @(negedge clk);

        // Reset in the middle of a load.
        send_frame(16'h5000, 16'd1, 0, 31, -1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t4_rst_uzorak", bus.uzorak, '0);
        chk("t4_rst_ready", 960'(bus.s_ready), 960'(1));
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen |= bus.rez_valid;
        end
        chk("t4_no_stale_result", 960'(seen), 960'(0));
        send_frame(16'hA5A5, 16'd0, 0, 60, 59);
        chk("t4_uzorak", bus.uzorak, build(16'hA5A5, 16'd0));
        wait_result("t4_result");
        @(negedge clk);
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            seen |= bus.rez_valid;
        end
        chk("t4_single_result", 960'(seen), 960'(0));

        // Early s_last on beat 10.
        send_frame(16'h3000, 16'd1, 0, 11, 10);
        chk("t5_early_greska", 960'(bus.greska), 960'(FC));
        @(negedge clk);
        chk("t5_greska_pulse", 960'(bus.greska), 960'(0));
`ifdef UZORAK_FRAME_CHECK_EN
        send_frame(16'h4000, 16'd1, 0, 60, 59);
        chk("t5_uzorak", bus.uzorak, build(16'h4000, 16'd1));
`else
        send_frame(16'h3000, 16'd1, 11, 60, 59);
        chk("t5_uzorak", bus.uzorak, build(16'h3000, 16'd1));
`endif
        chk("t5_uzorak_valid", 960'(bus.uzorak_valid), 960'(1));
        wait_result("t5_result");
        @(negedge clk);

        // Missing s_last on beat 59.
        send_frame(16'h6000, 16'd1, 0, 60, -1);
        chk("t6_missing_greska", 960'(bus.greska), 960'(FC));
        chk("t6_uzorak_valid", 960'(bus.uzorak_valid), 960'(!FC));
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen |= bus.rez_valid;
            chk("t6_greska_quiet", 960'(bus.greska), 960'(0));
        end
        chk("t6_result_seen", 960'(seen), 960'(!FC));
        repeat (4) @(negedge clk);

        // Indicator sampled only on the capture edge.
        bus.rez_ready = 1'b0;
        bus.indikator_1 = 1'b0; bus.indikator_2 = 1'b0;
        send_frame(16'h7000, 16'd1, 0, 60, 59);
        @(negedge clk); bus.indikator_1 = 1'b1;
        @(negedge clk); bus.indikator_1 = 1'b0;
        @(negedge clk); bus.indikator_1 = 1'b1;
        @(negedge clk);
        chk("t7_rez_valid", 960'(bus.rez_valid), 960'(1));
        chk("t7_rez_1", 960'(bus.rez_1), 960'(1));
        bus.indikator_1 = 1'b0;
        @(negedge clk);
        chk("t7_rez_1_held", 960'(bus.rez_1), 960'(1));
        bus.rez_ready = 1'b1;
        @(negedge clk);
        chk("t7_release", 960'(bus.rez_valid), 960'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
